// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch stage.
//   OP_JMP / OP_CALL : opcodes (inst[31:26]) of absolute jumps
//   fetch_state_t    : fetch FSM state {FETCH, DRAIN}
//   fetch_entry_t    : one buffered fetch {pc, inst, pred_taken}
//   is_jump()        : true when a word carries a JMP or CALL opcode
package fetch_pkg;
  localparam logic [5:0] OP_JMP  = 6'b001100;
  localparam logic [5:0] OP_CALL = 6'b001101;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
  } fetch_entry_t;

  function automatic logic is_jump(input logic [31:0] inst);
    return (inst[31:26] == OP_JMP) || (inst[31:26] == OP_CALL);
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetch_entry_t between fetch and decode.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (ignored when full unless popping the same cycle)
//   pop      : drop head (ignored when empty)
//   flush    : empty the FIFO; wins over push/pop
//   head     : entry at the read pointer (all-zero after reset)
//   count    : number of valid entries, 0..DEPTH
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO can still take a write when the head leaves the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is reset so the head (and thus dec_pc/dec_inst) reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage upstream of decode.
// Owns the PC, issues single-outstanding word reads to instruction memory,
// buffers {pc, inst} in fetch_buffer and hands them to decode on valid/ready.
// A redirect flushes the buffer; if a read is still outstanding the unit
// enters DRAIN, waits for (and drops) that ack, then resumes at the target.
//   clk, rst          : clock, asynchronous active-high reset
//   imem_req/addr     : read request and word address, stable until ack
//   imem_ack/rdata    : read completion and instruction word
//   redirect_valid/pc : one-cycle flush-and-restart pulse with new PC
//   dec_valid/ready   : buffer head handshake to decode
//   dec_pc/dec_inst   : head entry
//   dec_pred_taken    : head was self-redirected (FETCH_JUMP_PREDICT_EN only)
// Build option: define FETCH_JUMP_PREDICT_EN to follow JMP/CALL targets in
// fetch instead of leaving them to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
`ifdef FETCH_JUMP_PREDICT_EN
  output logic [31:0] dec_inst,
  output logic        dec_pred_taken
`else
  output logic [31:0] dec_inst
`endif
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t  state;
  logic [31:0]   fetch_pc, target, next_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head, wdata;
  logic          acked, push, pred;

  // In DRAIN the old request must be held until acked regardless of buffer
  // state. The count test alone keeps the request stable while waiting, since
  // count can only fall until an ack arrives.
  assign imem_req  = !rst && ((state == DRAIN) || (count != CW'(BUF_DEPTH)));
  assign imem_addr = fetch_pc;
  assign acked     = imem_req && imem_ack;
  assign push      = acked && (state == FETCH) && !redirect_valid;

`ifdef FETCH_JUMP_PREDICT_EN
  assign pred    = is_jump(imem_rdata);
  assign next_pc = pred ? {fetch_pc[31:26], imem_rdata[25:0]} : fetch_pc + 32'd1;
`else
  assign pred    = 1'b0;
  assign next_pc = fetch_pc + 32'd1;
`endif

  assign wdata = '{pc: fetch_pc, inst: imem_rdata, pred_taken: pred};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      target   <= RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_valid) begin
            if (imem_req && !imem_ack) begin
              state  <= DRAIN;
              target <= redirect_pc;
            end else begin
              fetch_pc <= redirect_pc;
            end
          end else if (acked) begin
            fetch_pc <= next_pc;
          end
        end
        DRAIN: begin
          // Drained word is dropped; a redirect landing with the ack still wins.
          if (acked) begin
            state    <= FETCH;
            fetch_pc <= redirect_valid ? redirect_pc : target;
          end else if (redirect_valid) begin
            target <= redirect_pc;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (dec_valid && dec_ready),
    .flush (redirect_valid),
    .head  (head),
    .count (count)
  );

  assign dec_valid = (count != '0);
  assign dec_pc    = head.pc;
  assign dec_inst  = head.inst;

`ifdef FETCH_JUMP_PREDICT_EN
  assign dec_pred_taken = head.pred_taken;
`else
  logic unused_pred;
  assign unused_pred = head.pred_taken;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] JADDR = 32'h0400_0010;
  localparam logic [31:0] JWORD = {6'b001100, 26'h0000200};
`ifdef FETCH_JUMP_PREDICT_EN
  localparam logic [31:0] JNEXT = 32'h0400_0200;
  localparam logic        JPT   = 1'b1;
`else
  localparam logic [31:0] JNEXT = 32'h0400_0011;
  localparam logic        JPT   = 1'b0;
`endif

  logic        clk, rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_inst;
`ifdef FETCH_JUMP_PREDICT_EN
  logic        dec_pred_taken;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pt;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, n_deliv = 0;
  int lat = 0, wcnt = 0;
  bit sb_en = 0;
  logic [31:0] held_pc;

  fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
`ifdef FETCH_JUMP_PREDICT_EN
    .dec_inst       (dec_inst),
    .dec_pred_taken (dec_pred_taken)
`else
    .dec_inst       (dec_inst)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Memory: acks after `lat` wait cycles; word = address except one jump word.
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = (imem_addr == JADDR) ? JWORD : imem_addr;
  always @(posedge clk or posedge rst)
    if (rst) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{pc: start + i, inst: start + i, pt: 1'b0});
  endtask

  // Scoreboard: every decode handshake must match the next expected entry.
  always @(negedge clk) begin
    if (sb_en && !rst && dec_valid && dec_ready) begin
      exp_t e;
      n_deliv++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_empty: observed delivery pc %h expected none", dec_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", dec_pc, e.pc);
        chk("sb_inst", dec_inst, e.inst);
`ifdef FETCH_JUMP_PREDICT_EN
        chk("sb_pred", {31'b0, dec_pred_taken}, {31'b0, e.pt});
`endif
      end
    end
  end

  initial begin
    rst = 1; dec_ready = 1; redirect_valid = 0; redirect_pc = 0; lat = 0;
    #2;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_pc", dec_pc, 32'h0);
    chk("rst_inst", dec_inst, 32'h0);

    // Zero-wait streaming from RESET_PC.
    push_seq(32'h0, 64);
    repeat (2) tick();
    rst = 0; sb_en = 1;
    @(negedge clk);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", {31'b0, dec_valid}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("stream_addr", imem_addr, k);
      chk("stream_pc", dec_pc, k - 1);
    end

    // Decode stall: buffer fills, request drops, head holds.
    tick();
    dec_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, dec_valid}, 32'd1);
      chk("stall_pc", dec_pc, 32'd6);
      chk("stall_inst", dec_inst, 32'd6);
      if (i > 0) chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    tick();
    dec_ready = 1;
    repeat (4) tick();

    // Redirect with no request pending, then redirect during a 3-cycle wait.
    dec_ready = 0;
    repeat (3) tick();
    lat = 3; redirect_valid = 1; redirect_pc = 32'h5;
    sb.delete();
    @(negedge clk);
    chk("idle_redir_req", {31'b0, imem_req}, 32'd0);
    tick();
    redirect_valid = 0; dec_ready = 1;
    @(negedge clk);
    chk("r5_req", {31'b0, imem_req}, 32'd1);
    chk("r5_addr", imem_addr, 32'h5);
    chk("r5_valid", {31'b0, dec_valid}, 32'd0);
    tick();
    redirect_valid = 1; redirect_pc = 32'h100;
    push_seq(32'h100, 64);
    tick();
    redirect_valid = 0;
    @(negedge clk);
    chk("drain_req", {31'b0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h5);
    tick();
    @(negedge clk);
    chk("drain_ack", {31'b0, imem_ack}, 32'd1);
    chk("drain_ack_addr", imem_addr, 32'h5);
    chk("drain_ack_valid", {31'b0, dec_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("post_drain_req", {31'b0, imem_req}, 32'd1);
    chk("post_drain_addr", imem_addr, 32'h100);
    chk("post_drain_valid", {31'b0, dec_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("wait_valid", {31'b0, dec_valid}, 32'd0);
    end
    tick();
    @(negedge clk);
    chk("r100_valid", {31'b0, dec_valid}, 32'd1);
    chk("r100_pc", dec_pc, 32'h100);

    // Redirect coincident with ack and decode handshake.
    tick();
    lat = 0;
    repeat (3) tick();
    redirect_valid = 1; redirect_pc = 32'h200;
    @(negedge clk);
    chk("co_ack", {31'b0, imem_ack}, 32'd1);
    chk("co_valid", {31'b0, dec_valid}, 32'd1);
    tick();
    redirect_valid = 0;
    sb.delete();
    push_seq(32'h200, 64);
    @(negedge clk);
    chk("co_empty", {31'b0, dec_valid}, 32'd0);
    chk("co_addr", imem_addr, 32'h200);
    tick();
    @(negedge clk);
    chk("co_pc", dec_pc, 32'h200);

    // Jump word at JADDR.
    repeat (2) tick();
    redirect_valid = 1; redirect_pc = JADDR;
    tick();
    redirect_valid = 0;
    sb.delete();
    sb.push_back('{pc: JADDR, inst: JWORD, pt: JPT});
    push_seq(JNEXT, 32);
    @(negedge clk);
    chk("j_addr", imem_addr, JADDR);
    chk("j_ack", {31'b0, imem_ack}, 32'd1);
    tick();
    @(negedge clk);
    chk("j_next_addr", imem_addr, JNEXT);
    chk("j_pc", dec_pc, JADDR);
    chk("j_inst", dec_inst, JWORD);
`ifdef FETCH_JUMP_PREDICT_EN
    chk("j_pred", {31'b0, dec_pred_taken}, 32'd1);
`endif
    tick();
    @(negedge clk);
    chk("j_follow_pc", dec_pc, JNEXT);
`ifdef FETCH_JUMP_PREDICT_EN
    chk("j_follow_pred", {31'b0, dec_pred_taken}, 32'd0);
`endif

    // Reset in the middle of a memory wait.
    tick();
    lat = 7;
    repeat (2) tick();
    @(negedge clk);
    chk("mid_req", {31'b0, imem_req}, 32'd1);
    chk("mid_ack", {31'b0, imem_ack}, 32'd0);
    sb_en = 0;
    rst = 1;
    #1;
    chk("mrst_req", {31'b0, imem_req}, 32'd0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_valid", {31'b0, dec_valid}, 32'd0);
    chk("mrst_pc", dec_pc, 32'h0);
    chk("mrst_inst", dec_inst, 32'h0);
`ifdef FETCH_JUMP_PREDICT_EN
    chk("mrst_pred", {31'b0, dec_pred_taken}, 32'd0);
`endif
    sb.delete();
    push_seq(32'h0, 32);
    repeat (2) tick();
    lat = 0; rst = 0; sb_en = 1;
    @(negedge clk);
    chk("rel_req", {31'b0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    repeat (5) tick();
    @(negedge clk);
    chk("rel_stream_pc", dec_pc, 32'd4);
    dec_ready = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
